mul_share_arbiter: RTL and testbench

Round-robin scheduler that shares one 2-stage pipelined constant multiplier (the ×3547 shift-add unit, P = A·3547) between two requesters. It grants at most one operand per cycle into the multiplier and tracks the owner of each in-flight product with a tag pipeline. Each product is returned to its owner through a per-channel result FIFO with valid/ready handshake. Per-channel credits guarantee the FIFOs never overflow. The block sits between the arctan numerator producers and the shared multiplier instance.

---
 rtl/mul_share_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_mul_share_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter
//
// Round-robin scheduler sharing one pipelined constant multiplier
// (P = A * 3547) between two requesters. At most one operand is granted per
// cycle. A tag pipeline follows each operand through the multiplier so that
// the product can be steered back to the channel that issued it. Each
// channel owns a small result FIFO with a valid/ready handshake. A per-channel
// credit counter covers both in-flight and stored results, so a product
// always has a free FIFO slot when it arrives.
//
// Parameters
//   A_WIDTH      signed operand width
//   P_WIDTH      signed product width (multiplier output)
//   MUL_LATENCY  cycles from mul_in_valid sampled to mul_out_valid
//   RES_DEPTH    per-channel result FIFO depth (power of two, >= MUL_LATENCY)
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   reqN_valid/data/ready     operand request from channel N; ready = grant
//   mul_in_valid, mul_a       operand issued to the shared multiplier
//   mul_out_valid, mul_p      product returned by the multiplier
//   resN_valid/data/ready     head of channel N's result FIFO; pop on handshake
//   busy                      some channel has in-flight or stored results
//   err_tag                   sticky: product/tag pipeline misalignment seen

module mul_share_arbiter #(
  parameter int A_WIDTH     = 9,
  parameter int P_WIDTH     = 21,
  parameter int MUL_LATENCY = 2,
  parameter int RES_DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  input  logic [A_WIDTH-1:0] req0_data,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [A_WIDTH-1:0] req1_data,
  output logic               req1_ready,
  output logic               mul_in_valid,
  output logic [A_WIDTH-1:0] mul_a,
  input  logic               mul_out_valid,
  input  logic [P_WIDTH-1:0] mul_p,
  output logic               res0_valid,
  output logic [P_WIDTH-1:0] res0_data,
  input  logic               res0_ready,
  output logic               res1_valid,
  output logic [P_WIDTH-1:0] res1_data,
  input  logic               res1_ready,
  output logic               busy,
  output logic               err_tag
);

  localparam int PTR_W = $clog2(RES_DEPTH);
  localparam int CNT_W = $clog2(RES_DEPTH + 1);

  // Per-channel views of the flat port list, indexed by channel number.
  logic [1:0]         req_valid;
  logic [A_WIDTH-1:0] req_data [2];
  logic [1:0]         res_ready_w;
  logic [1:0]         res_valid_w;
  logic [P_WIDTH-1:0] res_data_w [2];

  logic [1:0] elig;
  logic [1:0] grant;
  logic [1:0] fifo_push;
  logic [1:0] busy_ch;

  logic prio_reg;
  logic prio_next;

  // Tag pipeline: bit i of each vector is stage i; stage 0 is loaded on issue.
  logic [MUL_LATENCY-1:0] tag_v_reg;
  logic [MUL_LATENCY-1:0] tag_id_reg;
  logic                   tag_v_last;
  logic                   tag_id_last;

  logic err_tag_reg;
  logic err_tag_next;

  assign req_valid   = {req1_valid, req0_valid};
  assign req_data[0] = req0_data;
  assign req_data[1] = req1_data;
  assign res_ready_w = {res1_ready, res0_ready};

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign res0_valid = res_valid_w[0];
  assign res1_valid = res_valid_w[1];
  assign res0_data  = res_data_w[0];
  assign res1_data  = res_data_w[1];
  assign busy       = |busy_ch;
  assign err_tag    = err_tag_reg;

  assign tag_v_last  = tag_v_reg[MUL_LATENCY-1];
  assign tag_id_last = tag_id_reg[MUL_LATENCY-1];

  // ---------------------------------------------------------------------
  // Per-channel credit counter and result FIFO
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic [CNT_W-1:0]   cnt_reg;
      logic [CNT_W-1:0]   cnt_next;
      // One extra pointer bit distinguishes full from empty.
      logic [PTR_W:0]     wr_ptr_reg;
      logic [PTR_W:0]     rd_ptr_reg;
      logic [P_WIDTH-1:0] mem [RES_DEPTH];
      logic               pop;

      assign pop            = res_valid_w[gi] & res_ready_w[gi];
      assign res_valid_w[gi] = (wr_ptr_reg != rd_ptr_reg);
      // The head must be visible in the same cycle the FIFO becomes
      // non-empty, so the storage is read asynchronously at rd_ptr.
      assign res_data_w[gi]  = mem[rd_ptr_reg[PTR_W-1:0]];

      // A channel may only issue while it still owns a free FIFO slot,
      // counting products that are still inside the multiplier.
      assign elig[gi]      = req_valid[gi] && (cnt_reg < CNT_W'(RES_DEPTH));
      assign busy_ch[gi]   = (cnt_reg != '0);
      assign fifo_push[gi] = mul_out_valid && tag_v_last && (tag_id_last == 1'(gi));

      always_comb begin
        cnt_next = cnt_reg;
        if (grant[gi] && !pop) begin
          cnt_next = cnt_reg + 1'b1;
        end else if (!grant[gi] && pop) begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg    <= '0;
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
          if (fifo_push[gi]) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
          end
          if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
          end
        end
      end

      // Storage carries no reset; validity comes from the pointers alone.
      always_ff @(posedge clk) begin
        if (fifo_push[gi]) begin
          mem[wr_ptr_reg[PTR_W-1:0]] <= mul_p;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Round-robin arbitration
  // ---------------------------------------------------------------------
  always_comb begin
    grant     = '0;
    prio_next = prio_reg;
    if (elig[0] && (!elig[1] || !prio_reg)) begin
      grant[0] = 1'b1;
    end else if (elig[1]) begin
      grant[1] = 1'b1;
    end
    // The channel just served yields priority to the other one.
    if (grant[0]) begin
      prio_next = 1'b1;
    end else if (grant[1]) begin
      prio_next = 1'b0;
    end
  end

  always_comb begin
    mul_in_valid = grant[0] | grant[1];
    mul_a        = '0;
    if (grant[0]) begin
      mul_a = req_data[0];
    end else if (grant[1]) begin
      mul_a = req_data[1];
    end
  end

  // A product without a live tag, or a live tag without a product, both mean
  // the multiplier latency no longer matches the tag pipeline.
  assign err_tag_next = err_tag_reg | (mul_out_valid != tag_v_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_reg    <= 1'b0;
      tag_v_reg   <= '0;
      tag_id_reg  <= '0;
      err_tag_reg <= 1'b0;
    end else begin
      prio_reg      <= prio_next;
      err_tag_reg   <= err_tag_next;
      tag_v_reg[0]  <= mul_in_valid;
      tag_id_reg[0] <= grant[1];
      for (int i = 1; i < MUL_LATENCY; i++) begin
        tag_v_reg[i]  <= tag_v_reg[i-1];
        tag_id_reg[i] <= tag_id_reg[i-1];
      end
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Testbench for mul_share_arbiter. Contains a 2-stage x3547 multiplier model
// (sharing rst) plus a queue-based reference of per-channel outstanding
// results, and drives a directed-then-random sequence from one initial block.

module tb_mul_share_arbiter;

  localparam int AW = 9;
  localparam int PW = 21;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          mul_in_valid;
  logic [AW-1:0] mul_a;
  logic          mul_out_valid;
  logic [PW-1:0] mul_p;
  logic          res0_valid, res1_valid;
  logic [PW-1:0] res0_data, res1_data;
  logic          res0_ready, res1_ready;
  logic          busy, err_tag;

  logic          inj_valid;
  logic [PW-1:0] inj_p;
  logic          m1_v, m2_v;
  logic [PW-1:0] m1_p, m2_p;

  mul_share_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .mul_in_valid(mul_in_valid), .mul_a(mul_a),
    .mul_out_valid(mul_out_valid), .mul_p(mul_p),
    .res0_valid(res0_valid), .res0_data(res0_data), .res0_ready(res0_ready),
    .res1_valid(res1_valid), .res1_data(res1_data), .res1_ready(res1_ready),
    .busy(busy), .err_tag(err_tag)
  );

  always #5 clk = ~clk;

  // Shared constant multiplier: two register stages, cleared by rst.
  always @(posedge clk) begin
    if (rst) begin
      m1_v <= 1'b0; m2_v <= 1'b0; m1_p <= '0; m2_p <= '0;
    end else begin
      m1_v <= mul_in_valid;
      m1_p <= PW'(int'($signed(mul_a)) * 3547);
      m2_v <= m1_v;
      m2_p <= m1_p;
    end
  end
  assign mul_out_valid = m2_v | inj_valid;
  assign mul_p         = inj_valid ? inj_p : m2_p;

  // Reference: each channel's queue holds every accepted operand's product
  // with the first cycle it may be seen; its size is that channel's credit use.
  typedef struct {
    int            rc;
    logic [PW-1:0] p;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  bit   prio_m;
  bit   err_m;
  int   cyc;
  int   total;
  int   bad;
  int   pop_log0[$];
  int   grant_log[$];
  int   ch1_grants;

  function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endfunction

  task automatic set_in(bit v0, bit v1, bit r0, bit r1);
    req0_valid = v0;
    req1_valid = v1;
    res0_ready = r0;
    res1_ready = r1;
    req0_data  = AW'($urandom_range(0, 511));
    req1_data  = AW'($urandom_range(0, 511));
  endtask

  // Check one cycle against the reference, advance the reference across the
  // rising edge, and return at the following falling edge.
  task automatic tick();
    bit   e0, e1, g0, g1, rv0, rv1;
    exp_t e;
    #1;
    e0  = req0_valid && (q0.size() < 4);
    e1  = req1_valid && (q1.size() < 4);
    g0  = e0 && (!e1 || !prio_m);
    g1  = e1 && (!e0 || prio_m);
    rv0 = (q0.size() > 0) && (q0[0].rc <= cyc);
    rv1 = (q1.size() > 0) && (q1[0].rc <= cyc);

    chk("req0_ready", req0_ready, g0);
    chk("req1_ready", req1_ready, g1);
    chk("mul_in_valid", mul_in_valid, g0 | g1);
    chk("mul_a", mul_a, g0 ? req0_data : (g1 ? req1_data : AW'(0)));
    chk("res0_valid", res0_valid, rv0);
    chk("res1_valid", res1_valid, rv1);
    if (rv0) chk("res0_data", res0_data, q0[0].p);
    if (rv1) chk("res1_data", res1_data, q1[0].p);
    chk("busy", busy, (q0.size() + q1.size()) > 0);
    chk("err_tag", err_tag, err_m);

    if (req0_ready === 1'b1) grant_log.push_back(0);
    else if (req1_ready === 1'b1) grant_log.push_back(1);
    if (req1_ready === 1'b1) ch1_grants++;
    if (res0_valid === 1'b1 && res0_ready) pop_log0.push_back(int'($signed(res0_data)));

    if (rst) begin
      q0.delete();
      q1.delete();
      prio_m = 1'b0;
      err_m  = 1'b0;
    end else begin
      if (rv0 && res0_ready) void'(q0.pop_front());
      if (rv1 && res1_ready) void'(q1.pop_front());
      if (g0) begin
        e.rc = cyc + 3;
        e.p  = PW'(int'($signed(req0_data)) * 3547);
        q0.push_back(e);
        prio_m = 1'b1;
      end else if (g1) begin
        e.rc = cyc + 3;
        e.p  = PW'(int'($signed(req1_data)) * 3547);
        q1.push_back(e);
        prio_m = 1'b0;
      end
      if (inj_valid) err_m = 1'b1;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; ch1_grants = 0;
    prio_m = 1'b0; err_m = 1'b0;
    inj_valid = 1'b0; inj_p = '0;
    rst = 1'b1;
    set_in(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state with no requests.
    set_in(0, 0, 0, 0);
    repeat (2) tick();

    // Single channel 0: 1, 255, -256.
    pop_log0.delete();
    set_in(1, 0, 1, 1);
    req0_data = 9'd1;   tick();
    req0_data = 9'd255; tick();
    req0_data = 9'h100; tick();
    set_in(0, 0, 1, 1);
    repeat (5) tick();
    chk("dir_count", pop_log0.size(), 3);
    while (pop_log0.size() < 3) pop_log0.push_back(0);
    chk("dir_p0", pop_log0[0], 3547);
    chk("dir_p1", pop_log0[1], 904485);
    chk("dir_p2", pop_log0[2], -908032);

    // Both channels continuously, starting from reset.
    rst = 1'b1; set_in(0, 0, 1, 1); tick(); rst = 1'b0;
    grant_log.delete();
    repeat (20) begin set_in(1, 1, 1, 1); tick(); end
    while (grant_log.size() < 4) grant_log.push_back(-1);
    chk("alt_g0", grant_log[0], 0);
    chk("alt_g1", grant_log[1], 1);
    chk("alt_g2", grant_log[2], 0);
    chk("alt_g3", grant_log[3], 1);
    set_in(0, 0, 1, 1);
    repeat (6) tick();

    // Backpressure on channel 1, then a single pop.
    rst = 1'b1; tick(); rst = 1'b0;
    ch1_grants = 0;
    repeat (14) begin set_in(1, 1, 1, 0); tick(); end
    chk("bp_ch1_grants", ch1_grants, 4);
    set_in(1, 1, 1, 1); tick();
    repeat (8) begin set_in(1, 1, 1, 0); tick(); end
    chk("bp_ch1_resume", ch1_grants, 5);
    set_in(0, 0, 1, 1);
    repeat (10) tick();

    // Random traffic and backpressure.
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (400) begin
      set_in($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 70,
             $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 60);
      tick();
    end

    // Reset with two products in flight and three stored.
    rst = 1'b1; set_in(0, 0, 0, 0); tick(); rst = 1'b0;
    repeat (3) begin set_in(1, 0, 0, 0); tick(); end
    set_in(0, 1, 0, 0); tick();
    set_in(1, 0, 0, 0); tick();
    set_in(0, 0, 0, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    #1;
    chk("rst_res0_valid", res0_valid, 0);
    chk("rst_res1_valid", res1_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_tag", err_tag, 0);
    set_in(0, 0, 1, 1);
    repeat (6) tick();
    set_in(1, 1, 1, 1); tick();
    set_in(0, 0, 1, 1);
    repeat (6) tick();

    // Stray product with nothing in flight.
    inj_p = PW'($urandom);
    inj_valid = 1'b1; tick(); inj_valid = 1'b0;
    repeat (4) tick();
    chk("inj_err_tag", err_tag, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
